hilo_unit: RTL and testbench
============================

# hilo_unit

- Multi-cycle HI/LO register unit directly downstream of the 32-bit ALU.
- Captures the ALU's 64-bit secondary result for multiply-class and move-to ops (MULT, MULTU, MADD, MSUB, MTHI, MTLO) and commits it to the architectural HI/LO registers.
- Multiply-class results commit after a configurable latency. HI/LO values are fed back to the ALU's `ALUhi`/`ALUlo` inputs.
- Raises a stall to the hazard unit while any HI/LO-touching instruction would observe or overwrite an uncommitted multiply result.

## Interface

Parameters:
- `MUL_LATENCY`, default 4: cycles from multiply-class issue edge to HI/LO commit edge; legal range 1–15.

Ports:
- `Clk` in 1: single clock; all state on rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `ALUInstruction` in 6: EX-stage ALU opcode, same encoding the ALU consumes.
- `Valid` in 1: EX-stage instruction is real (not a bubble).
- `Flush` in 1: kill the EX-stage instruction this cycle.
- `ALUResult2` in 64: ALU secondary result `{hi, lo}` for the EX instruction.
- `ALUhi` out 32: HI value presented to the ALU.
- `ALUlo` out 32: LO value presented to the ALU.
- `Stall` out 1: combinational; hold the EX instruction and stages upstream.
- `Busy` out 1: registered; a multiply-class result is pending.

## Operation

Opcode classes:
- MUL: 19 MULTU, 20 MADD, 21 MSUB, 22 MULT.
- MT: 25 MTHI, 26 MTLO.
- MF: 27 MFHI, 24 MFLO.
- HILO = MUL ∪ MT ∪ MF. All other opcodes are ignored.

Issue and stall:
- `issue = Valid & ~Flush & ~Stall & (op in MUL ∪ MT)`.
- `Stall = Valid & ~Flush & (op in HILO) & hazard`.
- `hazard = (cnt != 0)`; with `HILO_FORWARD_EN`, `hazard = (cnt > 1)`.
- MADD/MSUB read HI/LO, so they stall like MF while busy.

State:
- `hi`, `lo` (architectural), `pend[63:0]`, `cnt[3:0]`.

MUL issue:
- `pend <= ALUResult2`, `cnt <= MUL_LATENCY`.

MT issue:
- MTHI writes `hi <= ALUResult2[63:32]` at the same edge; MTLO writes `lo <= ALUResult2[31:0]`.

Counter:
- `cnt` decrements by 1 each cycle while nonzero.
- At the edge where `cnt == 1`: `{hi, lo} <= pend`.

Simultaneous events on a commit edge:
- Commit is applied first; an MT issuing on the same edge then overwrites only its half.
- A MUL issuing on the commit edge (forward mode only) reloads `pend`/`cnt` after the commit.

Flush:
- Suppresses issue of the current instruction only.
- An in-flight multiply is architecturally older, so it continues and commits.

Outputs:
- `ALUhi`/`ALUlo` = `hi`/`lo` (registered).
- With forwarding and `cnt == 1`: they present `pend` instead.

Reset (`Rst_n` low, asynchronous): `hi`, `lo`, `pend` = 0; `cnt` = 0; `Busy` = 0.
- `Stall` is 0 by construction.
- Reset mid-multiply discards `pend`; no commit occurs.

## Timing

- MUL issue at edge E: `Busy` high from E through E+L−1; commit at edge E+L.
- Without forwarding: a dependent MF/MADD in the cycle after E stalls until the cycle after E+L, then reads committed HI/LO. Issue-to-use distance is L+1 cycles.
- With forwarding: the stall drops in the cycle before E+L, and the dependent reads `pend` on the bypass. Distance is L cycles.
- MT-to-MF needs no stall: the MT write lands at the edge, and the MF in the next cycle reads the new value.
- `MUL_LATENCY = 1`: `cnt` is 1 for exactly one cycle; with forwarding, no stall is ever raised.

## Configuration

`HILO_FORWARD_EN`:
- Defined: bypass `pend` onto `ALUhi`/`ALUlo` in the `cnt == 1` cycle, and stall only while `cnt > 1`.
- Undefined: no bypass mux; stall while `cnt != 0`; outputs always come straight from `hi`/`lo` flops.

## Structure

Shared package `hilo_pkg` holds:
- Localparams for opcodes 19–22 and 24–27.
- Functions `is_mul_op`, `is_mt_op`, `is_mf_op`.
- The `MUL_LATENCY` range check.
- The ALU decoder imports the same opcode constants.

One sub-module, `hilo_busy_ctr`:
- Loadable down-counter with load, value, `busy`, and `commit` (`cnt == 1`) outputs.
- The top level holds the HI/LO/pending registers and the stall logic.

## Test plan

All directed cases use L = 4.

- **Reset:** `Rst_n` low mid-operation → `ALUhi = ALUlo = 0`, `Busy = 0`, `Stall = 0` immediately (asynchronous).
- **MULT issue, then MFHI next cycle:**
  - Stimulus: MULT with `ALUResult2 = 0x00000001_FFFFFFFE`, then MFHI next cycle.
  - Response: `Stall` high 4 cycles (3 with forwarding); MFHI then sees `ALUhi = 0x00000001`.
- **MTLO, then MFLO back-to-back:** MTLO with `A = 0xDEADBEEF` (`ALUResult2[31:0] = 0xDEADBEEF`), MFLO next → no stall, `ALUlo = 0xDEADBEEF`.
- **MTHI on commit edge:**
  - Stimulus: MTHI `0x12345678` arriving on the commit edge of a MULT with pend `0xAAAAAAAA_55555555` (forward build).
  - Response: `hi = 0x12345678`, `lo = 0x55555555`.
- **Flush during busy:**
  - Stimulus: MULT issued, then `Flush` with MFLO at `cnt = 2`.
  - Response: no stall that cycle; commit still at E+4 with pend value.
- **Back-to-back MULTs:**
  - Stimulus: MULT A issued, MULT B `Valid` next cycle.
  - Response: B stalls until A commits, issues, and commits 4 edges later; final `{hi, lo}` equals B's `ALUResult2`.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: opcode constants and decode helpers shared by hilo_unit and the ALU decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_pkg;

  typedef logic [5:0] alu_op_t;

  // HI/LO-related ALU opcodes; the ALU decoder uses the same encodings
  localparam alu_op_t OP_MULTU = 6'd19;
  localparam alu_op_t OP_MADD  = 6'd20;
  localparam alu_op_t OP_MSUB  = 6'd21;
  localparam alu_op_t OP_MULT  = 6'd22;
  localparam alu_op_t OP_MFLO  = 6'd24;
  localparam alu_op_t OP_MTHI  = 6'd25;
  localparam alu_op_t OP_MTLO  = 6'd26;
  localparam alu_op_t OP_MFHI  = 6'd27;

  // Bounds of the multiply latency; the down-counter is 4 bits wide
  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 15;
  localparam int CNT_W       = 4;

  // Multiply-class ops: write pend and start the latency counter
  function automatic logic is_mul_op(input alu_op_t op);
    return (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MSUB)  || (op == OP_MULT);
  endfunction

  // Move-to ops: write one half of HI/LO directly
  function automatic logic is_mt_op(input alu_op_t op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // Move-from ops: only read HI/LO
  function automatic logic is_mf_op(input alu_op_t op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

  // Any op that observes or overwrites HI/LO
  function automatic logic is_hilo_op(input alu_op_t op);
    return is_mul_op(op) || is_mt_op(op) || is_mf_op(op);
  endfunction

  // Legal range for the MUL_LATENCY parameter
  function automatic logic mul_lat_ok(input int lat);
    return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
  endfunction

endpackage

// File: rtl/hilo_busy_ctr.sv
// hilo_busy_ctr: loadable down-counter tracking the pending multiply result.
// Latency: load takes effect at the loading edge; busy/commit are registered.
// Backpressure: none; the caller gates load with its own stall logic.
module hilo_busy_ctr
  import hilo_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             commit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             commit_q, commit_d;

  // Next count: a load wins over the decrement; it lands after a commit on the same edge
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    busy_d   = (cnt_d != '0);
    commit_d = (cnt_d == CNT_W'(1));
  end

  // Count plus pre-decoded status flags so busy/commit come straight from flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign busy_o   = busy_q;
  assign commit_o = commit_q;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers fed by the ALU secondary result; optional HILO_FORWARD_EN bypass.
// Latency: MT writes at the issue edge; multiply-class results commit MUL_LATENCY edges after issue.
// Backpressure: combinational Stall holds EX while a HI/LO op would see an uncommitted multiply.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [5:0]  ALUInstruction,
  input  logic        Valid,
  input  logic        Flush,
  input  logic [63:0] ALUResult2,
  output logic [31:0] ALUhi,
  output logic [31:0] ALUlo,
  output logic        Stall,
  output logic        Busy
);

  // Reject out-of-range latencies at elaboration
  if (!mul_lat_ok(MUL_LATENCY)) begin : g_bad_latency
    $error("hilo_unit: MUL_LATENCY must be within 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(MUL_LATENCY);

  logic             op_mul, op_mt, op_hilo, op_mthi;
  logic             live, hazard, issue, issue_mul, issue_mt;
  logic [CNT_W-1:0] cnt;
  logic             busy, commit;

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      pend_q, pend_d;

  // Opcode classification of the EX-stage instruction
  always_comb begin
    op_mul  = is_mul_op(ALUInstruction);
    op_mt   = is_mt_op(ALUInstruction);
    op_hilo = is_hilo_op(ALUInstruction);
    op_mthi = (ALUInstruction == OP_MTHI);
  end

`ifdef HILO_FORWARD_EN
  // In the commit cycle the bypass supplies pend, so only earlier cycles are hazardous
  assign hazard = (cnt > CNT_W'(1));
`else
  // Any pending multiply blocks HI/LO access until it has committed
  assign hazard = (cnt != '0);
`endif

  // Stall and issue qualification; hazard comes from flops, so there is no loop through Stall
  always_comb begin
    live      = Valid & ~Flush;
    Stall     = live & op_hilo & hazard;
    issue     = live & ~Stall & (op_mul | op_mt);
    issue_mul = issue & op_mul;
    issue_mt  = issue & op_mt;
  end

  hilo_busy_ctr u_busy_ctr (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .load_i     (issue_mul),
    .load_val_i (LAT_VAL),
    .cnt_o      (cnt),
    .busy_o     (busy),
    .commit_o   (commit)
  );

  // Next HI/LO: commit of the pending multiply first, then an MT overwrites only its half
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = pend_q;
    if (commit) begin
      hi_d = pend_q[63:32];
      lo_d = pend_q[31:0];
    end
    if (issue_mt) begin
      if (op_mthi) begin
        hi_d = ALUResult2[63:32];
      end else begin
        lo_d = ALUResult2[31:0];
      end
    end
    if (issue_mul) begin
      pend_d = ALUResult2;
    end
  end

  // Architectural HI/LO and the pending multiply result; reset discards anything in flight
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
    end
  end

`ifdef HILO_FORWARD_EN
  // In the commit cycle present the about-to-commit value to the ALU
  always_comb begin
    ALUhi = commit ? pend_q[63:32] : hi_q;
    ALUlo = commit ? pend_q[31:0]  : lo_q;
  end
`else
  // Outputs come straight from the architectural flops
  always_comb begin
    ALUhi = hi_q;
    ALUlo = lo_q;
  end
`endif

  assign Busy = busy;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: self-checking bench for hilo_unit at MUL_LATENCY = 4.
// Latency: expectations follow the default or HILO_FORWARD_EN build.
// Backpressure: stalled instructions are held until Stall drops (bounded wait).
module tb_hilo_unit;

  localparam int L = 4;
  localparam logic [5:0] T_MULTU = 6'd19;
  localparam logic [5:0] T_MULT  = 6'd22;
  localparam logic [5:0] T_MFLO  = 6'd24;
  localparam logic [5:0] T_MTHI  = 6'd25;
  localparam logic [5:0] T_MTLO  = 6'd26;
  localparam logic [5:0] T_MFHI  = 6'd27;

`ifdef HILO_FORWARD_EN
  localparam int EXP_DEP_STALLS = L - 1;
  localparam int EXP_CE_STALLS  = 0;
`else
  localparam int EXP_DEP_STALLS = L;
  localparam int EXP_CE_STALLS  = 1;
`endif

  logic        Clk;
  logic        Rst_n;
  logic [5:0]  ALUInstruction;
  logic        Valid;
  logic        Flush;
  logic [63:0] ALUResult2;
  logic [31:0] ALUhi;
  logic [31:0] ALUlo;
  logic        Stall;
  logic        Busy;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];

  hilo_unit #(.MUL_LATENCY(L)) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .ALUInstruction (ALUInstruction),
    .Valid          (Valid),
    .Flush          (Flush),
    .ALUResult2     (ALUResult2),
    .ALUhi          (ALUhi),
    .ALUlo          (ALUlo),
    .Stall          (Stall),
    .Busy           (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]  op;
    logic        vld;
    logic        fl;
    logic [63:0] res;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic v, input logic f, input logic [63:0] r);
    ALUInstruction = op;
    Valid          = v;
    Flush          = f;
    ALUResult2     = r;
  endtask

  task automatic idle();
    drive(6'd0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Hold the driven instruction until it is not stalled; n counts stalled cycles
  task automatic wait_issue(output int n);
    bit done;
    n    = 0;
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge Clk);
      if (Stall !== 1'b1) begin
        done = 1;
      end else begin
        n++;
        @(posedge Clk);
        #1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL stall_timeout actual=stuck expected=release");
    end
  endtask

  // Compare the value the ALU sees for an accepted MF against the scoreboard head
  task automatic sb_pop_check(input string name, input logic [63:0] act);
    logic [63:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=%h expected=scoreboard_entry", name, act);
    end else begin
      exp = sb_q.pop_front();
      check(name, act, exp);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;

    vecs[0] = '{T_MTLO, 1'b1, 1'b0, 64'h11111111_DEADBEEF, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[1] = '{T_MFLO, 1'b1, 1'b0, 64'h0,                 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{T_MTHI, 1'b1, 1'b0, 64'hCAFEF00D_00000000, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[3] = '{T_MTHI, 1'b1, 1'b1, 64'h99999999_99999999, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[4] = '{T_MTLO, 1'b0, 1'b0, 64'h77777777_77777777, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[5] = '{6'd0,   1'b1, 1'b0, 64'h12121212_34343434, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[6] = '{6'd23,  1'b1, 1'b0, 64'h56565656_78787878, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[7] = '{T_MTLO, 1'b1, 1'b0, 64'hFFFFFFFF_00000001, 32'hCAFE_F00D, 32'h0000_0001};

    // Reset state
    Rst_n = 1'b1;
    idle();
    #1 Rst_n = 1'b0;
    #2;
    check("rst_hi", {32'd0, ALUhi}, 64'd0);
    check("rst_lo", {32'd0, ALUlo}, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_stall", {63'd0, Stall}, 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    step();

    // Table: single-cycle ops with nothing pending
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].vld, vecs[i].fl, vecs[i].res);
      @(negedge Clk);
      check($sformatf("vec%0d_stall", i), {63'd0, Stall}, 64'd0);
      step();
      check($sformatf("vec%0d_hi", i), {32'd0, ALUhi}, {32'd0, vecs[i].exp_hi});
      check($sformatf("vec%0d_lo", i), {32'd0, ALUlo}, {32'd0, vecs[i].exp_lo});
      check($sformatf("vec%0d_busy", i), {63'd0, Busy}, 64'd0);
    end
    idle();
    step();

    // MTLO then MFLO back-to-back: no stall, new value visible
    drive(T_MTLO, 1'b1, 1'b0, 64'h0000_0000_DEAD_BEEF);
    step();
    drive(T_MFLO, 1'b1, 1'b0, 64'd0);
    sb_q.push_back({32'd0, 32'hDEAD_BEEF});
    wait_issue(n);
    check("mt_mf_stalls", 64'(n), 64'd0);
    sb_pop_check("mt_mf_lo", {32'd0, ALUlo});
    step();
    idle();

    // MULT then dependent MFHI
    drive(T_MULT, 1'b1, 1'b0, 64'h00000001_FFFFFFFE);
    step();
    check("mult_busy", {63'd0, Busy}, 64'd1);
    drive(T_MFHI, 1'b1, 1'b0, 64'd0);
    sb_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
    wait_issue(n);
    check("mult_mf_stalls", 64'(n), 64'(EXP_DEP_STALLS));
    sb_pop_check("mult_mf_hilo", {ALUhi, ALUlo});
    step();
    idle();
    step();
    check("mult_idle_busy", {63'd0, Busy}, 64'd0);

    // MTHI arriving in the commit cycle of a pending MULT
    drive(T_MULT, 1'b1, 1'b0, 64'hAAAAAAAA_55555555);
    step();
    idle();
    step();
    step();
    step();
    drive(T_MTHI, 1'b1, 1'b0, 64'h12345678_00000000);
    wait_issue(n);
    check("ce_stalls", 64'(n), 64'(EXP_CE_STALLS));
    step();
    idle();
    check("ce_hilo", {ALUhi, ALUlo}, 64'h12345678_55555555);
    check("ce_busy", {63'd0, Busy}, 64'd0);

    // Flushed MFLO while busy: no stall, multiply still commits at E+4
    drive(T_MULT, 1'b1, 1'b0, 64'h0BADF00D_CAFEBABE);
    step();
    idle();
    step();
    step();
    drive(T_MFLO, 1'b1, 1'b1, 64'd0);
    @(negedge Clk);
    check("flush_stall", {63'd0, Stall}, 64'd0);
    step();
    idle();
    check("flush_busy_pre", {63'd0, Busy}, 64'd1);
    step();
    check("flush_commit", {ALUhi, ALUlo}, 64'h0BADF00D_CAFEBABE);
    check("flush_busy_post", {63'd0, Busy}, 64'd0);

    // Back-to-back MULTs: second waits for the first, then commits L edges later
    drive(T_MULT, 1'b1, 1'b0, 64'h11112222_33334444);
    step();
    drive(T_MULTU, 1'b1, 1'b0, 64'h55556666_77778888);
    wait_issue(n);
    check("b2b_stalls", 64'(n), 64'(EXP_DEP_STALLS));
    step();
    idle();
    check("b2b_busy", {63'd0, Busy}, 64'd1);
    check("b2b_first", {ALUhi, ALUlo}, 64'h11112222_33334444);
    repeat (L) step();
    check("b2b_second", {ALUhi, ALUlo}, 64'h55556666_77778888);
    check("b2b_busy_end", {63'd0, Busy}, 64'd0);

    // Asynchronous reset mid-multiply discards the pending result
    drive(T_MULT, 1'b1, 1'b0, 64'hFEDCBA98_76543210);
    step();
    drive(T_MFHI, 1'b1, 1'b0, 64'd0);
    #1 Rst_n = 1'b0;
    #1;
    check("arst_hi", {32'd0, ALUhi}, 64'd0);
    check("arst_lo", {32'd0, ALUlo}, 64'd0);
    check("arst_busy", {63'd0, Busy}, 64'd0);
    check("arst_stall", {63'd0, Stall}, 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    idle();
    repeat (L + 2) step();
    check("arst_no_commit", {ALUhi, ALUlo}, 64'd0);
    check("arst_busy_after", {63'd0, Busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
